// File: rtl/lamp_pwm_driver.sv
// One-hot lamp code to PWM drive with optional fade-in ramp and fault latch.
// Define LAMP_RAMP_EN to enable the fade-in; otherwise lamps switch to full on.
module lamp_pwm_driver #(
    parameter int PWM_BITS      = 4,
    parameter int RAMP_STEP_CYC = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [0:3] light,
    output logic [0:3] lamp_out,
    output logic [0:3] active_code,
    output logic       ramping,
    output logic       fault,
    output logic [7:0] fault_cnt
);

    localparam logic [PWM_BITS:0] FULL = {1'b1, {PWM_BITS{1'b0}}};

    typedef enum logic [1:0] {IDLE, RAMP, ON, FAULT} state_t;

    state_t              state_q, state_d;
    logic [0:3]          light_q;
    logic [0:3]          code_q, code_d;
    logic [PWM_BITS:0]   duty_q, duty_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [7:0]          fcnt_q, fcnt_d;
    logic                valid;
    logic                load;

    if (RAMP_STEP_CYC < 1) begin : g_bad_step
        $error("RAMP_STEP_CYC must be >= 1");
    end

`ifdef LAMP_RAMP_EN
    localparam int STEP_W = (RAMP_STEP_CYC > 1) ? $clog2(RAMP_STEP_CYC) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP_CYC - 1);
    localparam logic [PWM_BITS:0] DUTY_LAST = FULL - 1'b1;

    logic [STEP_W-1:0] step_q, step_d;
`endif

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign valid = (light_q != 4'b0000) &&
                   ((light_q & (light_q - 4'd1)) == 4'b0000);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        duty_d  = duty_q;
        fcnt_d  = fcnt_q;
        load    = 1'b0;
`ifdef LAMP_RAMP_EN
        step_d  = step_q;
`endif
        if (!valid) begin
            state_d = FAULT;
            code_d  = '0;
            duty_d  = '0;
`ifdef LAMP_RAMP_EN
            step_d  = '0;
`endif
            if (state_q != FAULT && fcnt_q != 8'hFF) begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end else begin
            load = (state_q == IDLE) || (state_q == FAULT) ||
                   (light_q != code_q);
            if (load) begin
                code_d = light_q;
`ifdef LAMP_RAMP_EN
                state_d = RAMP;
                duty_d  = '0;
                step_d  = '0;
`else
                state_d = ON;
                duty_d  = FULL;
`endif
            end
`ifdef LAMP_RAMP_EN
            else if (state_q == RAMP) begin
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    duty_d = duty_q + 1'b1;
                    if (duty_q == DUTY_LAST) begin
                        state_d = ON;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            light_q <= '0;
            code_q  <= '0;
            duty_q  <= '0;
            pwm_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            light_q <= light;
            code_q  <= code_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_q + 1'b1;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef LAMP_RAMP_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign ramping = (state_q == RAMP);
`else
    assign ramping = 1'b0;
`endif

    assign lamp_out    = code_q & {4{({1'b0, pwm_q} < duty_q)}};
    assign active_code = code_q;
    assign fault       = (state_q == FAULT);
    assign fault_cnt   = fcnt_q;

endmodule

// File: tb/tb_lamp_pwm_driver.sv
// Testbench for lamp_pwm_driver: vector table, corner sequences, random run
// against a time-based reference model (follows LAMP_RAMP_EN like the DUT).
module tb_lamp_pwm_driver;

    localparam int PERIOD = 16;
    localparam int STEP   = 2;
`ifdef LAMP_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic [0:3] light;
    logic [0:3] lamp_out;
    logic [0:3] active_code;
    logic       ramping;
    logic       fault;
    logic [7:0] fault_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    lamp_pwm_driver #(
        .PWM_BITS      (4),
        .RAMP_STEP_CYC (STEP)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .light       (light),
        .lamp_out    (lamp_out),
        .active_code (active_code),
        .ramping     (ramping),
        .fault       (fault),
        .fault_cnt   (fault_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: time since the current code was loaded sets the duty.
    logic [0:3] m_lq   = '0;
    logic [0:3] m_code = '0;
    int         m_t    = 0;
    bit         m_idle = 1'b1;
    bit         m_flt  = 1'b0;
    int         m_cnt  = 0;
    int         m_pwm  = 0;

    task automatic check(input string name, input bit ok, input string detail);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @%0t: %s", name, $time, detail);
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            m_lq = '0; m_code = '0; m_t = 0; m_idle = 1'b1;
            m_flt = 1'b0; m_cnt = 0; m_pwm = 0;
        end else begin
            if ($countones(m_lq) != 1) begin
                if (!m_flt && m_cnt < 255) m_cnt++;
                m_flt = 1'b1; m_idle = 1'b0; m_code = '0; m_t = 0;
            end else if (m_idle || m_flt || m_lq != m_code) begin
                m_code = m_lq; m_t = 0; m_idle = 1'b0; m_flt = 1'b0;
            end else if (m_t < 1000) begin
                m_t++;
            end
            m_pwm = (m_pwm + 1) % PERIOD;
            m_lq  = light;
        end
    endtask

    task automatic check_model();
        int         duty;
        logic [0:3] e_lamp;
        bit         e_ramp;
        if (m_idle || m_flt) duty = 0;
        else if (RAMP_EN) duty = (m_t / STEP < PERIOD) ? m_t / STEP : PERIOD;
        else duty = PERIOD;
        e_lamp = (m_pwm < duty) ? m_code : 4'b0000;
        e_ramp = RAMP_EN && !m_idle && !m_flt && (m_t / STEP < PERIOD);
        check("model",
              lamp_out === e_lamp && active_code === m_code &&
              ramping === e_ramp && fault === m_flt &&
              fault_cnt === 8'(m_cnt),
              $sformatf("got lamp=%b code=%b ramp=%b flt=%b cnt=%0d, want lamp=%b code=%b ramp=%b flt=%b cnt=%0d",
                        lamp_out, active_code, ramping, fault, fault_cnt,
                        e_lamp, m_code, e_ramp, m_flt, m_cnt));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       rst_n;
        logic [0:3] light;
        logic [0:3] code;
        logic       flt;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit ok;
        reset_n = 1'b0;
        light   = 4'b0000;

        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 4'b1000, 4'b0000, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 4'b1000, 4'b0000, 1'b1, 8'd1};
        tbl[3]  = '{1'b1, 4'b1000, 4'b1000, 1'b0, 8'd1};
        tbl[4]  = '{1'b1, 4'b0100, 4'b1000, 1'b0, 8'd1};
        tbl[5]  = '{1'b1, 4'b0100, 4'b0100, 1'b0, 8'd1};
        tbl[6]  = '{1'b1, 4'b0110, 4'b0100, 1'b0, 8'd1};
        tbl[7]  = '{1'b1, 4'b0110, 4'b0000, 1'b1, 8'd2};
        tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 8'd2};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 8'd2};
        tbl[10] = '{1'b1, 4'b0010, 4'b0000, 1'b1, 8'd2};
        tbl[11] = '{1'b1, 4'b0010, 4'b0010, 1'b0, 8'd2};
        tbl[12] = '{1'b1, 4'b1111, 4'b0010, 1'b0, 8'd2};
        tbl[13] = '{1'b1, 4'b0001, 4'b0000, 1'b1, 8'd3};
        tbl[14] = '{1'b1, 4'b0001, 4'b0001, 1'b0, 8'd3};
        tbl[15] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 8'd0};

        for (int i = 0; i < 16; i++) begin
            reset_n = tbl[i].rst_n;
            light   = tbl[i].light;
            tick();
            check($sformatf("vec%0d", i),
                  active_code === tbl[i].code && fault === tbl[i].flt &&
                  fault_cnt === tbl[i].cnt,
                  $sformatf("got code=%b flt=%b cnt=%0d, want code=%b flt=%b cnt=%0d",
                            active_code, fault, fault_cnt,
                            tbl[i].code, tbl[i].flt, tbl[i].cnt));
        end

        // Power-on with a steady code: lamp reaches full drive.
        light = 4'b1000;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("start_code", active_code === 4'b1000,
              $sformatf("got %b want 1000", active_code));
`ifdef LAMP_RAMP_EN
        check("ramp_start", ramping === 1'b1 && lamp_out === 4'b0000,
              $sformatf("got ramp=%b lamp=%b want 1/0000", ramping, lamp_out));
        repeat (31) tick();
        check("ramp_hold", ramping === 1'b1,
              $sformatf("got ramp=%b want 1", ramping));
        tick();
        check("ramp_done", ramping === 1'b0,
              $sformatf("got ramp=%b want 0", ramping));
`else
        check("on_start", ramping === 1'b0 && lamp_out === 4'b1000,
              $sformatf("got ramp=%b lamp=%b want 0/1000", ramping, lamp_out));
`endif
        ok = 1'b1;
        repeat (16) begin
            tick();
            if (lamp_out !== 4'b1000 || ramping !== 1'b0) ok = 1'b0;
        end
        check("full_on", ok, $sformatf("last lamp=%b ramp=%b want 1000/0", lamp_out, ramping));

        // Code switch takes effect at the second edge.
        light = 4'b0100;
        tick();
        check("switch_e1", active_code === 4'b1000,
              $sformatf("got %b want 1000", active_code));
        tick();
        check("switch_e2", active_code === 4'b0100,
              $sformatf("got %b want 0100", active_code));
`ifdef LAMP_RAMP_EN
        check("switch_duty0", lamp_out === 4'b0000 && ramping === 1'b1,
              $sformatf("got lamp=%b ramp=%b want 0000/1", lamp_out, ramping));
        light = 4'b0010;
        tick();
        tick();
        repeat (10) tick();
        light = 4'b0001;
        tick();
        tick();
        check("ramp_restart",
              active_code === 4'b0001 && ramping === 1'b1 && lamp_out === 4'b0000,
              $sformatf("got code=%b ramp=%b lamp=%b want 0001/1/0000",
                        active_code, ramping, lamp_out));
`else
        check("switch_lamp", lamp_out === 4'b0100 && ramping === 1'b0,
              $sformatf("got lamp=%b ramp=%b want 0100/0", lamp_out, ramping));
`endif

        // Many separate fault entries saturate the counter.
        for (int i = 0; i < 300; i++) begin
            light = 4'b0001;
            tick();
            light = 4'b0000;
            tick();
        end
        tick();
        check("fcnt_sat", fault_cnt === 8'd255 && fault === 1'b1,
              $sformatf("got cnt=%0d flt=%b want 255/1", fault_cnt, fault));

        // Single-edge reset mid-operation clears everything.
        light = 4'b0010;
        repeat (6) tick();
        reset_n = 1'b0;
        tick();
        check("mid_reset",
              lamp_out === 4'b0000 && active_code === 4'b0000 &&
              ramping === 1'b0 && fault === 1'b0 && fault_cnt === 8'd0,
              $sformatf("got lamp=%b code=%b ramp=%b flt=%b cnt=%0d want all 0",
                        lamp_out, active_code, ramping, fault, fault_cnt));
        reset_n = 1'b1;

        // Random traffic: mostly steady valid codes, some changes and glitches.
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset_n = 1'b1;
            if (r < 20) light = 4'b1000 >> $urandom_range(0, 3);
            else if (r < 27) light = 4'($urandom_range(0, 15));
            else if (r < 29) reset_n = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lamp_pwm_driver.md
LAMP_PWM_DRIVER -- requirements
Module: lamp_pwm_driver

Interface
REQ-001 Parameter PWM_BITS, default 4: PWM counter width; period = 2^PWM_BITS cycles.
REQ-002 Parameter RAMP_STEP_CYC, default 2: clock cycles per duty increment during a fade-in (legal range >= 1).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 light  input  [0:3]  one-hot colour code from the lamp sequencer: bit0 R, bit1 G, bit2 Y, bit3 B.
REQ-006 lamp_out  output  [0:3]  PWM drive per lamp, same bit order as light.
REQ-007 active_code  output  [0:3]  code currently being driven.
REQ-008 ramping  output  1  high while a fade-in is in progress.
REQ-009 fault  output  1  high while in FAULT.
REQ-010 fault_cnt  output  [7:0]  saturating count of FAULT entries.

Function
REQ-011 light SHALL be registered into light_q every cycle; the FSM SHALL act only on light_q, so a change on light affects outputs at the second rising edge after it is applied.
REQ-012 A code SHALL be valid iff exactly one bit is set; 0000 and any multi-bit code SHALL be invalid.
REQ-013 FSM states: IDLE, RAMP, ON, FAULT.
REQ-014 pwm_cnt (PWM_BITS wide) SHALL free-run from reset, incrementing every cycle and wrapping from 2^PWM_BITS-1 to 0.
REQ-015 duty SHALL be PWM_BITS+1 bits wide, range 0..2^PWM_BITS.
REQ-016 lamp_out[i] SHALL equal active_code[i] AND (pwm_cnt < duty); duty = 2^PWM_BITS SHALL give a constant high; duty = 0 SHALL give a constant low.
REQ-017 IDLE: valid light_q SHALL load active_code, clear duty, and enter RAMP; invalid light_q SHALL enter FAULT.
REQ-018 RAMP: duty SHALL increment by 1 every RAMP_STEP_CYC cycles; on reaching 2^PWM_BITS the FSM SHALL enter ON.
REQ-019 RAMP or ON: a valid light_q different from active_code SHALL load it, clear duty and the step timer, and (re)enter RAMP. An equal code SHALL cause no change.
REQ-020 Any state: an invalid light_q SHALL enter FAULT with duty = 0 and active_code = 0000. Invalid input SHALL take priority over every other transition.
REQ-021 FAULT: the FSM SHALL remain while light_q is invalid; a valid light_q SHALL load active_code, clear duty, and enter RAMP.
REQ-022 fault_cnt SHALL increment once on each entry into FAULT, not per cycle in FAULT, and SHALL saturate at 255.
REQ-023 ramping SHALL equal (state == RAMP); fault SHALL equal (state == FAULT).

Reset
REQ-024 While reset_n is low at a rising edge: state = IDLE, light_q = 0000, active_code = 0000, duty = 0, pwm_cnt = 0, step timer = 0, fault_cnt = 0.
REQ-025 Outputs under reset: lamp_out = 0000, ramping = 0, fault = 0.
REQ-026 Reset asserted mid-RAMP or in FAULT SHALL abandon the operation with no residual state; fault_cnt SHALL clear.

Configuration
REQ-027 Macro LAMP_RAMP_EN defined: fade-in behaviour per REQ-018/019.
REQ-028 Macro LAMP_RAMP_EN undefined: every entry to RAMP SHALL instead go directly to ON with duty = 2^PWM_BITS; RAMP SHALL be unreachable; ramping SHALL be constant 0; the step timer SHALL be omitted.

Verification (PWM_BITS=4, RAMP_STEP_CYC=2, LAMP_RAMP_EN defined unless noted)
REQ-029 Reset then hold light=1000 -> RAMP entered 2 edges later; duty reaches 16 after 32 further cycles; state ON; lamp_out = 1000 constantly; ramping falls.
REQ-030 In ON with 1000, switch light to 0100 -> active_code = 0100 after 2 edges; duty restarts at 0; lamp_out[1] high for duty of 16 pwm_cnt values.
REQ-031 Mid-RAMP at duty=5, change light 0010->0001 -> duty clears to 0; ramp restarts; ramping stays high.
REQ-032 Apply light=0110 for 3 cycles, then 0000 for 2 cycles, then 0010 -> fault high, lamp_out = 0000, fault_cnt = 1 (single entry), then recovery to RAMP with 0010.
REQ-033 Force 300 separate FAULT entries -> fault_cnt = 255; reset_n low for 1 edge mid-RAMP -> all REQ-024 values.
REQ-034 LAMP_RAMP_EN undefined, light=0001 -> ON with lamp_out = 0001 at the second edge; ramping never high.
